// File: rtl/sysace_cmd_sched_pkg.sv
// sysace_cmd_sched_pkg: shared types and helpers for the SystemACE read scheduler
//   state_t      one-hot FSM encoding
//   SECTOR_WORDS 16-bit words per sector
//   clog2_min1   $clog2 clamped to at least 1 bit
package sysace_cmd_sched_pkg;
    localparam int SECTOR_WORDS = 256;
    typedef enum logic [5:0] {
        IDLE      = 6'b000001,
        START     = 6'b000010,
        WAIT_BUSY = 6'b000100,
        XFER      = 6'b001000,
        DONE      = 6'b010000,
        RECOVER   = 6'b100000
    } state_t;
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sysace_cmd_sched_if.sv
// sysace_cmd_sched_if: request, controller and completion signals of the scheduler
//   req_*      per-channel requests (valid/ready, packed lba and sector count)
//   sysace_*   command and handshake towards the SystemACE MPU controller
//   done_*     per-command completion strobe, channel and error flag
//   sched_busy/q_level  scheduler status
//   master = scheduler view, slave = environment view
interface sysace_cmd_sched_if
    import sysace_cmd_sched_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int QDEPTH = 4,
    parameter int LBA_W  = 28,
    parameter int NSEC_W = 8
);
    localparam int CH_W  = clog2_min1(NCH);
    localparam int LVL_W = $clog2(QDEPTH) + 1;
    logic [NCH-1:0]        req_valid;
    logic [NCH-1:0]        req_ready;
    logic [NCH*LBA_W-1:0]  req_lba;
    logic [NCH*NSEC_W-1:0] req_nsectors;
    logic [LBA_W-1:0]      sysace_mpulba;
    logic [NSEC_W-1:0]     sysace_nsectors;
    logic                  sysace_start;
    logic                  sysace_busy;
    logic                  sysace_read_avail;
    logic                  done_valid;
    logic [CH_W-1:0]       done_ch;
    logic                  done_err;
    logic                  sched_busy;
    logic [LVL_W-1:0]      q_level;
    modport master (
        input  req_valid, req_lba, req_nsectors, sysace_busy, sysace_read_avail,
        output req_ready, sysace_mpulba, sysace_nsectors, sysace_start,
               done_valid, done_ch, done_err, sched_busy, q_level
    );
    modport slave (
        output req_valid, req_lba, req_nsectors, sysace_busy, sysace_read_avail,
        input  req_ready, sysace_mpulba, sysace_nsectors, sysace_start,
               done_valid, done_ch, done_err, sched_busy, q_level
    );
endinterface

// File: rtl/sysace_cmd_sched_busy_filter.sv
// sysace_busy_filter: hysteresis filter accepting a level change only after DEPTH equal samples
//   clk, rst_n  clock, asynchronous active-low reset
//   din         raw busy level
//   dout        filtered busy level
module sysace_busy_filter #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);
    logic [DEPTH-1:0] sh;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh   <= '0;
            dout <= 1'b0;
        end else begin
            sh   <= DEPTH'({sh, din});
            dout <= (&sh) ? 1'b1 : (~|sh) ? 1'b0 : dout;
        end
    end
endmodule

// File: rtl/sysace_cmd_sched.sv
// sysace_cmd_sched: round-robin multi-channel read scheduler in front of the SystemACE MPU controller
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         sysace_cmd_sched_if.master: requests in, controller command/handshake, completions out
module sysace_cmd_sched
    import sysace_cmd_sched_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int QDEPTH    = 4,
    parameter int BUSY_FILT = 3,
    parameter int LBA_W     = 28,
    parameter int NSEC_W    = 8,
    parameter int TMO_W     = 20
) (
    input logic clk,
    input logic rst_n,
    sysace_cmd_sched_if.master bus
);
    localparam int CH_W   = clog2_min1(NCH);
    localparam int QA_W   = $clog2(QDEPTH);
    localparam int SW_LOG = $clog2(SECTOR_WORDS);
    localparam int WC_W   = NSEC_W + 1 + SW_LOG;
    state_t            state;
    logic [QA_W:0]     wr_ptr, rd_ptr;
    logic [CH_W-1:0]   rr_ptr, gch, idx, cur_ch;
    logic [CH_W-1:0]   q_ch   [QDEPTH];
    logic [LBA_W-1:0]  q_lba  [QDEPTH];
    logic [NSEC_W-1:0] q_nsec [QDEPTH];
    logic              found, full, empty, push, fbusy, err, tmo;
    logic [WC_W-1:0]   word_cnt, wc_nx, exp_words;
    logic [TMO_W-1:0]  tmo_cnt;
    sysace_busy_filter #(.DEPTH(BUSY_FILT)) u_filt (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (bus.sysace_busy),
        .dout (fbusy)
    );
    // first valid channel at or after rr_ptr
    always_comb begin
        found = 1'b0;
        gch   = '0;
        idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = CH_W'((int'(rr_ptr) + k) % NCH);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                gch   = idx;
            end
        end
    end
    // extra pointer bit distinguishes full from empty
    assign empty          = wr_ptr == rd_ptr;
    assign full           = (wr_ptr[QA_W] != rd_ptr[QA_W]) && (wr_ptr[QA_W-1:0] == rd_ptr[QA_W-1:0]);
    assign push           = found && !full;
    assign bus.req_ready  = push ? NCH'(1) << gch : '0;
    assign bus.q_level    = wr_ptr - rd_ptr;
    assign bus.sched_busy = !empty || state != IDLE;
    // a zero sector count stands for 2**NSEC_W sectors
    assign exp_words      = {bus.sysace_nsectors == '0, bus.sysace_nsectors, {SW_LOG{1'b0}}};
    assign wc_nx          = (bus.sysace_read_avail && !(&word_cnt)) ? word_cnt + 1'b1 : word_cnt;
    assign tmo            = &tmo_cnt;
    always_ff @(posedge clk) begin
        if (push) begin
            q_ch[wr_ptr[QA_W-1:0]]   <= gch;
            q_lba[wr_ptr[QA_W-1:0]]  <= bus.req_lba[gch*LBA_W +: LBA_W];
            q_nsec[wr_ptr[QA_W-1:0]] <= bus.req_nsectors[gch*NSEC_W +: NSEC_W];
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            rr_ptr              <= '0;
            cur_ch              <= '0;
            err                 <= 1'b0;
            word_cnt            <= '0;
            tmo_cnt             <= '0;
            bus.sysace_mpulba   <= '0;
            bus.sysace_nsectors <= '0;
            bus.sysace_start    <= 1'b0;
            bus.done_valid      <= 1'b0;
            bus.done_ch         <= '0;
            bus.done_err        <= 1'b0;
        end else begin
            bus.sysace_start <= 1'b0;
            bus.done_valid   <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= (gch == CH_W'(NCH - 1)) ? '0 : gch + 1'b1;
            end
            if (state == WAIT_BUSY || state == XFER)
                tmo_cnt <= (state == XFER && bus.sysace_read_avail) ? '0 : tmo ? tmo_cnt : tmo_cnt + 1'b1;
            case (state)
                IDLE: if (!empty) begin
                    rd_ptr              <= rd_ptr + 1'b1;
                    cur_ch              <= q_ch[rd_ptr[QA_W-1:0]];
                    bus.sysace_mpulba   <= q_lba[rd_ptr[QA_W-1:0]];
                    bus.sysace_nsectors <= q_nsec[rd_ptr[QA_W-1:0]];
                    bus.sysace_start    <= 1'b1;
                    state               <= START;
                end
                START: begin
                    word_cnt <= '0;
                    tmo_cnt  <= '0;
                    err      <= 1'b0;
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: if (fbusy) state <= XFER;
                    else if (tmo) begin
                        err   <= 1'b1;
                        state <= RECOVER;
                    end
                XFER: begin
                    word_cnt <= wc_nx;
                    if (!fbusy) begin
                        bus.done_valid <= 1'b1;
                        bus.done_ch    <= cur_ch;
                        bus.done_err   <= wc_nx != exp_words;
                        state          <= DONE;
                    end else if (tmo) begin
                        err   <= 1'b1;
                        state <= RECOVER;
                    end
                end
                // never hand out another command while the device still reports busy
                RECOVER: if (!fbusy) begin
                    bus.done_valid <= 1'b1;
                    bus.done_ch    <= cur_ch;
                    bus.done_err   <= err;
                    state          <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sysace_cmd_sched.sv
// tb_sysace_cmd_sched: self-checking bench for sysace_cmd_sched with a behavioural device and scoreboard
module tb_sysace_cmd_sched;
    localparam int NCH = 2, QDEPTH = 4, BUSY_FILT = 3, LBA_W = 28, NSEC_W = 4, TMO_W = 6;
    typedef struct { int ch; logic [LBA_W-1:0] lba; logic [NSEC_W-1:0] nsec; } cmd_t;
    typedef struct { int ch; bit err; int cyc; } done_t;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int errors = 0, checks = 0, cyc = 0, model_rr = 0;
    logic [LBA_W-1:0]  start_lba_q[$];
    logic [NSEC_W-1:0] start_nsec_q[$];
    int                start_cyc_q[$];
    done_t             done_q[$];

    sysace_cmd_sched_if #(.NCH(NCH), .QDEPTH(QDEPTH), .LBA_W(LBA_W), .NSEC_W(NSEC_W)) bus();
    sysace_cmd_sched #(.NCH(NCH), .QDEPTH(QDEPTH), .BUSY_FILT(BUSY_FILT), .LBA_W(LBA_W),
                       .NSEC_W(NSEC_W), .TMO_W(TMO_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.sysace_start) begin
                start_lba_q.push_back(bus.sysace_mpulba);
                start_nsec_q.push_back(bus.sysace_nsectors);
                start_cyc_q.push_back(cyc);
            end
            if (bus.done_valid) done_q.push_back('{ch: int'(bus.done_ch), err: bus.done_err, cyc: cyc});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        start_lba_q.delete();
        start_nsec_q.delete();
        start_cyc_q.delete();
        done_q.delete();
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        bus.req_lba = '0;
        bus.req_nsectors = '0;
        bus.sysace_busy = 1'b0;
        bus.sysace_read_avail = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        model_rr = 0;
        clear_q();
    endtask

    task automatic request(input int ch, input logic [LBA_W-1:0] lba, input logic [NSEC_W-1:0] nsec);
        bus.req_lba[ch*LBA_W +: LBA_W] = lba;
        bus.req_nsectors[ch*NSEC_W +: NSEC_W] = nsec;
        bus.req_valid[ch] = 1'b1;
        #1;
        for (int n = 0; n < 200 && !bus.req_ready[ch]; n++) tick();
        checks++;
        if (!bus.req_ready[ch]) begin
            errors++;
            $display("FAIL accept ch%0d: req_ready=%b required 1", ch, bus.req_ready[ch]);
        end
        tick();
        bus.req_valid[ch] = 1'b0;
    endtask

    task automatic wait_start(input int want);
        for (int n = 0; n < 300 && start_lba_q.size() < want; n++) tick();
        checks++;
        if (start_lba_q.size() < want) begin
            errors++;
            $display("FAIL start_seen: starts=%0d required %0d", start_lba_q.size(), want);
        end
    endtask

    task automatic wait_done(output done_t d, input int bound);
        for (int n = 0; n < bound && done_q.size() == 0; n++) tick();
        checks++;
        if (done_q.size() == 0) begin
            errors++;
            $display("FAIL done_seen: no done_valid within %0d cycles", bound);
            d = '{ch: -1, err: 1'b0, cyc: 0};
        end else d = done_q.pop_front();
    endtask

    // behavioural SystemACE device: rises busy, streams words, then drops busy
    task automatic serve(input int words, input int hold);
        repeat (5) tick();
        bus.sysace_busy = 1'b1;
        repeat (6) tick();
        for (int i = 0; i < words; i++) begin
            bus.sysace_read_avail = 1'b1;
            tick();
        end
        bus.sysace_read_avail = 1'b0;
        repeat (hold) tick();
        bus.sysace_busy = 1'b0;
    endtask

    function automatic int exp_words(input logic [NSEC_W-1:0] nsec);
        return (nsec == 0 ? (1 << NSEC_W) : int'(nsec)) * 256;
    endfunction

    task automatic test_reset();
        do_reset();
        checks++; if (bus.sysace_start !== 1'b0) begin errors++; $display("FAIL rst_start: got %b required 0", bus.sysace_start); end
        checks++; if (bus.sysace_mpulba !== '0) begin errors++; $display("FAIL rst_lba: got %0h required 0", bus.sysace_mpulba); end
        checks++; if (bus.done_valid !== 1'b0 || bus.done_err !== 1'b0 || bus.done_ch !== '0) begin
            errors++; $display("FAIL rst_done: got v=%b e=%b ch=%0d required 0", bus.done_valid, bus.done_err, bus.done_ch); end
        checks++; if (bus.q_level !== '0 || bus.sched_busy !== 1'b0) begin
            errors++; $display("FAIL rst_status: got lvl=%0d busy=%b required 0", bus.q_level, bus.sched_busy); end
    endtask

    task automatic test_basic();
        done_t d;
        clear_q();
        request(0, 28'h123, 4'd1);
        wait_start(1);
        serve(256, 38);
        wait_done(d, 40);
        checks++; if (start_lba_q.size() !== 1) begin errors++; $display("FAIL basic_starts: got %0d required 1", start_lba_q.size()); end
        checks++; if (start_lba_q[0] !== 28'h123) begin errors++; $display("FAIL basic_lba: got %0h required 123", start_lba_q[0]); end
        checks++; if (d.ch !== 0 || d.err !== 1'b0) begin errors++; $display("FAIL basic_done: got ch=%0d err=%b required ch=0 err=0", d.ch, d.err); end
    endtask

    // both channels valid every cycle; device silent so the first command parks in the FSM
    task automatic test_back_to_back();
        cmd_t exp_q[$];
        done_t d;
        int lvl_tab [10] = '{0, 1, 1, 2, 3, 4, 4, 4, 4, 4};
        logic [LBA_W-1:0] lba [NCH];
        logic [NSEC_W-1:0] ns [NCH];
        logic [NCH-1:0] exp_rdy;
        int g, c2;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < NCH; i++) begin
                lba[i] = LBA_W'($urandom);
                ns[i] = NSEC_W'($urandom_range(1, 15));
                bus.req_lba[i*LBA_W +: LBA_W] = lba[i];
                bus.req_nsectors[i*NSEC_W +: NSEC_W] = ns[i];
            end
            bus.req_valid = '1;
            #1;
            g = -1;
            if (lvl_tab[c] < QDEPTH)
                for (int k = 0; k < NCH && g < 0; k++) begin
                    c2 = (model_rr + k) % NCH;
                    if (bus.req_valid[c2]) g = c2;
                end
            exp_rdy = (g < 0) ? '0 : NCH'(1) << g;
            checks++; if (bus.req_ready !== exp_rdy) begin errors++; $display("FAIL b2b_ready c%0d: got %b required %b", c, bus.req_ready, exp_rdy); end
            checks++; if (int'(bus.q_level) !== lvl_tab[c]) begin errors++; $display("FAIL b2b_level c%0d: got %0d required %0d", c, bus.q_level, lvl_tab[c]); end
            if (g >= 0) begin
                exp_q.push_back('{ch: g, lba: lba[g], nsec: ns[g]});
                model_rr = (g + 1) % NCH;
            end
            tick();
        end
        bus.req_valid = '0;
        for (int i = 0; i < exp_q.size(); i++) begin
            wait_done(d, 120);
            checks++; if (d.ch !== exp_q[i].ch || d.err !== 1'b1) begin
                errors++; $display("FAIL b2b_done%0d: got ch=%0d err=%b required ch=%0d err=1", i, d.ch, d.err, exp_q[i].ch); end
            checks++; if (start_lba_q[i] !== exp_q[i].lba || start_nsec_q[i] !== exp_q[i].nsec) begin
                errors++; $display("FAIL b2b_cmd%0d: got %0h/%0d required %0h/%0d", i, start_lba_q[i], start_nsec_q[i], exp_q[i].lba, exp_q[i].nsec); end
        end
    endtask

    task automatic test_timeout();
        done_t d;
        int lat;
        logic [LBA_W-1:0] la = LBA_W'($urandom), lb = LBA_W'($urandom);
        clear_q();
        request(1, la, 4'd2);
        request(0, lb, 4'd1);
        wait_start(1);
        wait_done(d, 120);
        lat = d.cyc - start_cyc_q[0];
        checks++; if (d.ch !== 1 || d.err !== 1'b1) begin errors++; $display("FAIL tmo_done: got ch=%0d err=%b required ch=1 err=1", d.ch, d.err); end
        checks++; if (lat < 63 || lat > 70) begin errors++; $display("FAIL tmo_latency: got %0d required 63..70", lat); end
        wait_start(2);
        serve(256, 3);
        wait_done(d, 40);
        checks++; if (start_lba_q[1] !== lb) begin errors++; $display("FAIL tmo_next_lba: got %0h required %0h", start_lba_q[1], lb); end
        checks++; if (d.ch !== 0 || d.err !== 1'b0) begin errors++; $display("FAIL tmo_next_done: got ch=%0d err=%b required ch=0 err=0", d.ch, d.err); end
    endtask

    task automatic test_nsec_zero();
        done_t d;
        for (int t = 0; t < 2; t++) begin
            clear_q();
            request(t, LBA_W'($urandom), '0);
            wait_start(1);
            serve(exp_words('0) - t, 2);
            wait_done(d, 40);
            checks++; if (start_nsec_q[0] !== '0) begin errors++; $display("FAIL nsec0_cmd: got %0d required 0", start_nsec_q[0]); end
            checks++; if (d.ch !== t || d.err !== (t == 1)) begin
                errors++; $display("FAIL nsec0_done%0d: got ch=%0d err=%b required ch=%0d err=%0d", t, d.ch, d.err, t, t); end
        end
    endtask

    task automatic test_glitch();
        done_t d;
        clear_q();
        request(1, LBA_W'($urandom), 4'd1);
        wait_start(1);
        for (int w = 1; w <= 2; w++)
            repeat (2) begin
                bus.sysace_busy = 1'b1;
                repeat (w) tick();
                bus.sysace_busy = 1'b0;
                repeat (3) tick();
            end
        checks++; if (done_q.size() !== 0) begin errors++; $display("FAIL glitch_ignored: got %0d completions required 0", done_q.size()); end
        bus.sysace_busy = 1'b1;
        repeat (6) tick();
        for (int i = 0; i < 256; i++) begin
            bus.sysace_read_avail = 1'b1;
            tick();
        end
        bus.sysace_read_avail = 1'b0;
        repeat (2) tick();
        bus.sysace_busy = 1'b0;
        wait_done(d, 40);
        checks++; if (d.ch !== 1 || d.err !== 1'b0) begin errors++; $display("FAIL glitch_done: got ch=%0d err=%b required ch=1 err=0", d.ch, d.err); end
    endtask

    task automatic test_reset_mid();
        done_t d;
        clear_q();
        request(0, LBA_W'($urandom), 4'd1);
        request(1, LBA_W'($urandom), 4'd2);
        wait_start(1);
        repeat (5) tick();
        bus.sysace_busy = 1'b1;
        repeat (6) tick();
        bus.sysace_read_avail = 1'b1;
        repeat (50) tick();
        bus.sysace_read_avail = 1'b0;
        bus.sysace_busy = 1'b0;
        rst_n = 1'b0;
        tick();
        checks++; if (bus.q_level !== '0 || bus.sched_busy !== 1'b0 || bus.req_ready !== '0) begin
            errors++; $display("FAIL midrst_status: got lvl=%0d busy=%b rdy=%b required 0", bus.q_level, bus.sched_busy, bus.req_ready); end
        checks++; if (bus.sysace_mpulba !== '0 || bus.sysace_nsectors !== '0 || bus.sysace_start !== 1'b0 || bus.done_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_out: got lba=%0h ns=%0d st=%b dv=%b required 0", bus.sysace_mpulba, bus.sysace_nsectors, bus.sysace_start, bus.done_valid); end
        rst_n = 1'b1;
        repeat (10) tick();
        checks++; if (done_q.size() !== 0 || start_lba_q.size() !== 1) begin
            errors++; $display("FAIL midrst_quiet: got done=%0d starts=%0d required 0 and 1", done_q.size(), start_lba_q.size()); end
        clear_q();
        request(1, 28'hABCDE, 4'd1);
        wait_start(1);
        serve(256, 4);
        wait_done(d, 40);
        checks++; if (d.ch !== 1 || d.err !== 1'b0 || start_lba_q[0] !== 28'hABCDE) begin
            errors++; $display("FAIL midrst_fresh: got ch=%0d err=%b lba=%0h required ch=1 err=0 lba=abcde", d.ch, d.err, start_lba_q[0]); end
    endtask

    task automatic test_random();
        done_t d;
        cmd_t c;
        int delta;
        for (int t = 0; t < 6; t++) begin
            clear_q();
            c = '{ch: $urandom_range(0, NCH - 1), lba: LBA_W'($urandom), nsec: NSEC_W'($urandom_range(1, 3))};
            delta = $urandom_range(0, 2) - 1;
            request(c.ch, c.lba, c.nsec);
            wait_start(1);
            serve(exp_words(c.nsec) + delta, $urandom_range(0, 10));
            wait_done(d, 40);
            checks++; if (start_lba_q[0] !== c.lba || start_nsec_q[0] !== c.nsec) begin
                errors++; $display("FAIL rnd_cmd%0d: got %0h/%0d required %0h/%0d", t, start_lba_q[0], start_nsec_q[0], c.lba, c.nsec); end
            checks++; if (d.ch !== c.ch || d.err !== (delta != 0)) begin
                errors++; $display("FAIL rnd_done%0d: got ch=%0d err=%b required ch=%0d err=%0d", t, d.ch, d.err, c.ch, delta != 0); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_timeout();
        test_nsec_zero();
        test_glitch();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
